shift_add_mac: RTL and testbench
================================

Name: shift_add_mac

Overview:
- Sequential shift-add multiply-accumulate: computes product = x*y + z over DATA_WIDTH cycles.
- Producer/writer side of the modular-reduction datapath: its 2*DATA_WIDTH+1-bit result and done flag feed the modulo block's a/start inputs directly.
- Same start/done level protocol as the rest of the arithmetic units.

Parameters:
- DATA_WIDTH, 8, width of multiplicand x and multiplier y; z is 2*DATA_WIDTH wide; result is 2*DATA_WIDTH+1 wide.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  synchronous load/restart pulse; sampled every edge
- x  input  DATA_WIDTH  multiplicand, unsigned
- y  input  DATA_WIDTH  multiplier, unsigned
- z  input  2*DATA_WIDTH  addend, unsigned
- product  output  2*DATA_WIDTH+1  x*y+z, unsigned; valid while done=1
- done  output  1  result valid; level, held until next start or reset
- busy  output  1  high while computing

Behaviour:
- Reset (rst_n=0, async): state=IDLE, product=0, done=0, busy=0, internal count/shift registers=0. Reset mid-operation abandons the computation; no partial result is exposed.
- States: IDLE, MUL, DONE.
- start=1 at any edge, in any state (including mid-MUL and DONE), has priority:
  - latch x into a 2*DATA_WIDTH+1 shift register (zero-extended);
  - latch y into a multiplier register;
  - set the accumulator to zero-extended z;
  - count=0, done=0, busy=1, state=MUL.
  - Inputs are sampled only on that edge; later changes on x/y/z are ignored.
- MUL, each edge with start=0:
  - if the multiplier LSB is 1, acc += shifted x (full 2*DATA_WIDTH+1 width, no truncation possible);
  - x_sh <<= 1; y_sh >>= 1; count += 1;
  - when count==DATA_WIDTH-1 on this edge: state=DONE, done=1, busy=0.
- Latency: done rises at the DATA_WIDTH-th edge after the start edge (8 cycles for the default). Fixed, independent of operand values.
- DONE: product holds, done holds 1, busy=0 until the next start. IDLE behaves as DONE with done=0.
- product is driven directly from the accumulator register. Intermediate values are visible during MUL; consumers use them only when done=1.
- Width rule: max result (2^W-1)^2 + 2^(2W)-1 < 2^(2W+1), so no overflow is possible. The MSB is the only bit that can be set beyond 2W.
- start held high for several cycles: the block reloads every edge; computation begins on the first edge with start=0.
- done and busy are never high simultaneously.

Optional Feature:
- Macro: SHIFT_ADD_MAC_EARLY_TERM_EN.
- Defined: in MUL, if the post-shift multiplier register is zero, go to DONE on that same edge.
  - Latency = (index of highest set bit of y)+1 edges.
  - y=0 gives a latency of 1 edge with product=z.
  - Result values are identical to the non-early-termination build.
- Undefined: fixed DATA_WIDTH-edge latency as above; no zero-detect logic is synthesized.

Test Plan (DATA_WIDTH=8):
- Basic: start with x=13, y=11, z=7 -> product=150 (0x00096), done=1 exactly 8 edges after start, busy=1 for edges 1..7.
- Max operands: x=255, y=255, z=65535 -> product=130560 (0x1FE00), MSB set. Hold 3 idle cycles -> product and done unchanged.
- Zero multiplier: x=200, y=0, z=1234 -> product=1234 after 8 edges (after 1 edge with SHIFT_ADD_MAC_EARLY_TERM_EN).
- Restart mid-op: start x=9, y=9, z=0; at edge 4 pulse start with x=3, y=5, z=1 -> done only 8 edges after the second start, product=16; 81 never flagged done.
- Async reset mid-op: x=100, y=100, z=0; assert rst_n=0 between edges 3 and 4 -> product=0, done=0, busy=0 immediately. After release, start x=2, y=3, z=0 -> product=6.
- Early term (macro defined): y=1, x=77, z=0 -> done after 1 edge, product=77. y=0x80 -> done after 8 edges.

Source files
------------

// File: rtl/shift_add_mac.sv
// -----------------------------------------------------------------------------
// shift_add_mac
//   Sequential shift-add multiply-accumulate: product = x*y + z, computed one
//   multiplier bit per clock. Its result/done pair feeds the modular-reduction
//   block's a/start inputs directly.
//
//   Optional build macro: SHIFT_ADD_MAC_EARLY_TERM_EN
//     When defined, the operation finishes as soon as the remaining multiplier
//     bits are all zero. Latency becomes (index of the highest set bit of y)+1,
//     or 1 edge for y=0. Results are identical to the fixed-latency build.
//
// Parameters
//   DATA_WIDTH : width of x and y. z is 2*DATA_WIDTH wide, and the product is
//                2*DATA_WIDTH+1 wide.
//
// Ports
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   start   : load/restart. Sampled on every edge and wins in any state.
//   x       : multiplicand, unsigned
//   y       : multiplier, unsigned
//   z       : addend, unsigned
//   product : accumulator. Only meaningful while done=1.
//   done    : result valid. This is a level, held until the next start or reset.
//   busy    : high while computing
// -----------------------------------------------------------------------------
module shift_add_mac #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     x,
  input  logic [DATA_WIDTH-1:0]     y,
  input  logic [2*DATA_WIDTH-1:0]   z,
  output logic [2*DATA_WIDTH:0]     product,
  output logic                      done,
  output logic                      busy
);

  localparam int PW = 2 * DATA_WIDTH + 1;
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [PW-1:0]         acc_reg, acc_next;
  logic [PW-1:0]         x_sh_reg, x_sh_next;
  logic [DATA_WIDTH-1:0] y_sh_reg, y_sh_next;
  logic [CW-1:0]         count_reg, count_next;
  logic                  done_reg, done_next;
  logic                  busy_reg, busy_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      x_sh_reg  <= '0;
      y_sh_reg  <= '0;
      count_reg <= '0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      x_sh_reg  <= x_sh_next;
      y_sh_reg  <= y_sh_next;
      count_reg <= count_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    x_sh_next  = x_sh_reg;
    y_sh_next  = y_sh_reg;
    count_next = count_reg;
    done_next  = done_reg;
    busy_next  = busy_reg;

    if (start) begin
      // A restart takes priority in every state, including mid-multiply.
      x_sh_next  = {{(DATA_WIDTH + 1){1'b0}}, x};
      y_sh_next  = y;
      acc_next   = {1'b0, z};
      count_next = '0;
      done_next  = 1'b0;
      busy_next  = 1'b1;
      state_next = MUL;
    end else begin
      case (state_reg)
        MUL: begin
          // The accumulator is one bit wider than x*y or z alone, so this sum
          // can never wrap.
          if (y_sh_reg[0]) begin
            acc_next = acc_reg + x_sh_reg;
          end
          x_sh_next  = x_sh_reg << 1;
          y_sh_next  = y_sh_reg >> 1;
          count_next = count_reg + 1'b1;
          if (count_reg == LAST_COUNT) begin
            state_next = DONE;
            done_next  = 1'b1;
            busy_next  = 1'b0;
          end
`ifdef SHIFT_ADD_MAC_EARLY_TERM_EN
          // If no multiplier bits remain after this shift, the result is final.
          else if ((y_sh_reg >> 1) == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
            busy_next  = 1'b0;
          end
`endif
        end
        default: begin
          // IDLE and DONE both hold everything until the next start.
        end
      endcase
    end
  end

  assign product = acc_reg;
  assign done    = done_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_shift_add_mac.sv
module tb_shift_add_mac;

  localparam int W  = 8;
  localparam int PW = 2 * W + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [2*W-1:0] z;
  logic [PW-1:0] product;
  logic          done;
  logic          busy;

  shift_add_mac #(.DATA_WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .x       (x),
    .y       (y),
    .z       (z),
    .product (product),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int overlap  = 0;
  logic [PW-1:0] exp_q[$];

  // done and busy must never be high together.
  always @(negedge clk) begin
    if (rst_n && done && busy) overlap++;
  end

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] z;
    logic [PW-1:0]  exp;
    string          name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
      $display("check %-22s ok   actual=%0d", name, act);
    end else begin
      $display("FAIL %-22s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int exp_latency(input logic [W-1:0] yv);
`ifdef SHIFT_ADD_MAC_EARLY_TERM_EN
    int hb;
    hb = -1;
    for (int i = 0; i < W; i++) if (yv[i]) hb = i;
    return (hb < 0) ? 1 : hb + 1;
`else
    return W;
`endif
  endfunction

  // Drive one start edge; returns half a cycle after it with start low again.
  task automatic start_op(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic [2*W-1:0] zv);
    @(negedge clk);
    x = xv; y = yv; z = zv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count edges after the start edge until done. Then check the latency, that
  // busy was high before done, and the product against the scoreboard.
  task automatic wait_done(input int lat, input string name);
    int   k;
    logic busy_ok;
    logic [PW-1:0] e;
    k = 0;
    busy_ok = 1'b1;
    while (k < W + 4) begin
      @(posedge clk);
      #1;
      k++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
    if (exp_q.size() == 0) begin
      $display("FAIL %s_scoreboard actual=empty required=entry", name);
      n_checks++;
      return;
    end
    e = exp_q.pop_front();
    check({name, "_latency"}, k, lat);
    check({name, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
    check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({name, "_product"}, {15'd0, product}, {15'd0, e});
  endtask

  initial begin
    logic no_done;
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0; z = '0;

    vecs[0] = '{x: 8'd13,  y: 8'd11,  z: 16'd7,     exp: 17'd150,    name: "basic"};
    vecs[1] = '{x: 8'd255, y: 8'd255, z: 16'd65535, exp: 17'd130560, name: "max"};
    vecs[2] = '{x: 8'd200, y: 8'd0,   z: 16'd1234,  exp: 17'd1234,   name: "zero_mul"};
    vecs[3] = '{x: 8'd1,   y: 8'd1,   z: 16'd0,     exp: 17'd1,      name: "one_one"};
    vecs[4] = '{x: 8'd0,   y: 8'd255, z: 16'd5,     exp: 17'd5,      name: "zero_x"};
    vecs[5] = '{x: 8'd255, y: 8'h80,  z: 16'd0,     exp: 17'd32640,  name: "y_msb"};
    vecs[6] = '{x: 8'd77,  y: 8'd1,   z: 16'd0,     exp: 17'd77,     name: "y_one"};
    vecs[7] = '{x: 8'd100, y: 8'd3,   z: 16'd65535, exp: 17'd65835,  name: "carry_msb"};

    repeat (2) @(posedge clk);
    #1;
    check("reset_product", {15'd0, product}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vecs[i].exp);
      start_op(vecs[i].x, vecs[i].y, vecs[i].z);
      wait_done(exp_latency(vecs[i].y), vecs[i].name);
    end

    // Max operands, then hold idle and confirm the result sticks.
    exp_q.push_back(17'd130560);
    start_op(8'd255, 8'd255, 16'd65535);
    wait_done(exp_latency(8'd255), "max_again");
    repeat (3) @(posedge clk);
    #1;
    check("hold_product", {15'd0, product}, 32'd130560);
    check("hold_done", {31'd0, done}, 32'd1);
    check("hold_msb", {31'd0, product[PW-1]}, 32'd1);

    // Operand changes after the start edge must be ignored.
    exp_q.push_back(17'd42);
    start_op(8'd6, 8'd7, 16'd0);
    x = 8'd99; y = 8'd99; z = 16'd999;
    wait_done(exp_latency(8'd7), "inputs_ignored");

    // Restart mid-op. The first operation is abandoned, so it is not queued.
    start_op(8'd9, 8'd9, 16'd0);
    no_done = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) no_done = 1'b0;
    end
    exp_q.push_back(17'd16);
    start_op(8'd3, 8'd5, 16'd1);
    wait_done(exp_latency(8'd5), "restart");
    check("restart_no_early_done", {31'd0, no_done}, 32'd1);

    // Asynchronous reset between edges 3 and 4.
    start_op(8'd100, 8'd100, 16'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_product", {15'd0, product}, 32'd0);
    check("areset_done", {31'd0, done}, 32'd0);
    check("areset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(17'd6);
    start_op(8'd2, 8'd3, 16'd0);
    wait_done(exp_latency(8'd3), "after_reset");

    // start held high for three edges. Only the last load counts.
    @(negedge clk);
    start = 1'b1; x = 8'd50; y = 8'd50; z = 16'd50;
    @(posedge clk);
    @(negedge clk);
    x = 8'd60; y = 8'd61; z = 16'd62;
    @(posedge clk);
    #1;
    check("held_busy", {31'd0, busy}, 32'd1);
    check("held_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    x = 8'd4; y = 8'd5; z = 16'd2;
    exp_q.push_back(17'd22);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(exp_latency(8'd5), "held_start");

    check("done_busy_overlap", overlap, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
